// File: rtl/mul4_pkg.sv
// Shared definitions for the MUL4 product-accumulation stage.
// It holds the product and counter widths and the accumulator state encoding.
package mul4_pkg;

    localparam int PROD_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_t;

endpackage

// File: rtl/mul4_acc_if.sv
// Product-in / sum-out handshake bundle for mul4_acc.
// The master drives products and sum_ready. The slave (the accumulator) drives results.
interface mul4_acc_if
    import mul4_pkg::*;
#(
    parameter int ACC_W = 10
);

    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum;
    logic              sum_ovf;
    logic [CNT_W-1:0]  grp_cnt;

    modport master (
        output prod_valid, prod, sum_ready,
        input  prod_ready, sum_valid, sum, sum_ovf, grp_cnt
    );

    modport slave (
        input  prod_valid, prod, sum_ready,
        output prod_ready, sum_valid, sum, sum_ovf, grp_cnt
    );

endinterface

// File: rtl/mul4_acc.sv
// Sums each group of LEN unsigned MUL4 products into one registered result.
// Each result carries a sticky carry-out flag.
module mul4_acc
    import mul4_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    mul4_acc_if.slave   bus
);

    acc_state_t       state_r;
    acc_state_t       next_state_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_r;
    logic             ovf_r;
    logic             sum_ovf_r;
    logic             sum_valid_r;
    logic [CNT_W-1:0] cnt_r;

    logic             prod_ready_s;
    logic             accept_s;
    logic             first_s;
    logic             last_s;
    logic             flag_s;
    logic [ACC_W:0]   wide_s;

    // Upstream ready and the next accumulator/flag value for an accepted product
    always_comb begin
        prod_ready_s = 1'b0;
        if (clr) begin
            prod_ready_s = 1'b0;
        end else begin
            case (state_r)
                ACC:     prod_ready_s = 1'b1;
                OUT:     prod_ready_s = bus.sum_ready;
                default: prod_ready_s = 1'b0;
            endcase
        end
        accept_s = bus.prod_valid && prod_ready_s;
        // The count is zero in OUT, so a product accepted there starts a new group.
        first_s  = (cnt_r == CNT_W'(0));
        last_s   = (cnt_r == CNT_W'(LEN - 1));
        if (first_s) begin
            wide_s = (ACC_W + 1)'(bus.prod);
            flag_s = 1'b0;
        end else begin
            wide_s = {1'b0, acc_r} + (ACC_W + 1)'(bus.prod);
            flag_s = ovf_r | wide_s[ACC_W];
        end
    end

    // Next-state logic of the collect/hold FSM
    always_comb begin
        next_state_s = state_r;
        if (clr) begin
            next_state_s = ACC;
        end else begin
            case (state_r)
                ACC: begin
                    if (accept_s && last_s) next_state_s = OUT;
                    else                    next_state_s = ACC;
                end
                OUT: begin
                    if (accept_s && last_s) next_state_s = OUT;
                    else if (bus.sum_ready) next_state_s = ACC;
                    else                    next_state_s = OUT;
                end
                default: next_state_s = ACC;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ACC;
        else        state_r <= next_state_s;
    end

    // Accumulator, group counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            sum_ovf_r   <= 1'b0;
            sum_valid_r <= 1'b0;
        end else if (clr) begin
            // The last result stays readable after an abort.
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            cnt_r       <= '0;
            sum_ovf_r   <= 1'b0;
            sum_valid_r <= 1'b0;
        end else if (accept_s) begin
            acc_r <= wide_s[ACC_W-1:0];
            ovf_r <= flag_s;
            if (last_s) begin
                cnt_r       <= '0;
                sum_r       <= wide_s[ACC_W-1:0];
                sum_ovf_r   <= flag_s;
                sum_valid_r <= 1'b1;
            end else begin
                cnt_r       <= cnt_r + CNT_W'(1);
                sum_valid_r <= 1'b0;
            end
        end else if (state_r == OUT && bus.sum_ready) begin
            sum_valid_r <= 1'b0;
        end else begin
            sum_valid_r <= sum_valid_r;
        end
    end

    assign bus.prod_ready = prod_ready_s;
    assign bus.sum_valid  = sum_valid_r;
    assign bus.sum        = sum_r;
    assign bus.sum_ovf    = sum_ovf_r;
    assign bus.grp_cnt    = cnt_r;

endmodule

// File: tb/tb_mul4_acc.sv
// Directed bench for mul4_acc covering three configurations: LEN=4/ACC_W=10, LEN=4/ACC_W=9 and LEN=1.
module tb_mul4_acc;

    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   errors;

    mul4_acc_if #(.ACC_W(10)) a_if ();
    mul4_acc_if #(.ACC_W(9))  b_if ();
    mul4_acc_if #(.ACC_W(10)) c_if ();

    mul4_acc #(.LEN(4), .ACC_W(10)) u_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(a_if));
    mul4_acc #(.LEN(4), .ACC_W(9))  u_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b_if));
    mul4_acc #(.LEN(1), .ACC_W(10)) u_c (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed_a(input logic [7:0] v [4], input int n);
        a_if.prod_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            a_if.prod = v[i];
            tick();
        end
        a_if.prod_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        a_if.prod_valid = 1'b0; a_if.prod = 8'd0; a_if.sum_ready = 1'b1;
        b_if.prod_valid = 1'b0; b_if.prod = 8'd0; b_if.sum_ready = 1'b1;
        c_if.prod_valid = 1'b0; c_if.prod = 8'd0; c_if.sum_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_sum",       a_if.sum,        32'd0);
        chk("rst_sum_valid", a_if.sum_valid,  32'd0);
        chk("rst_sum_ovf",   a_if.sum_ovf,    32'd0);
        chk("rst_grp_cnt",   a_if.grp_cnt,    32'd0);
        chk("rst_prod_rdy",  a_if.prod_ready, 32'd1);

        // 225 x4: 900 fits in 10 bits and wraps to 388 in 9 bits
        a_if.prod_valid = 1'b1; b_if.prod_valid = 1'b1;
        a_if.prod = 8'd225;     b_if.prod = 8'd225;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) chk("a_grp_cnt", a_if.grp_cnt, 32'(i + 1));
        end
        a_if.prod_valid = 1'b0; b_if.prod_valid = 1'b0;
        chk("a_sum_valid",  a_if.sum_valid, 32'd1);
        chk("a_sum_900",    a_if.sum,       32'd900);
        chk("a_ovf_0",      a_if.sum_ovf,   32'd0);
        chk("a_cnt_wrap",   a_if.grp_cnt,   32'd0);
        chk("b_sum_388",    b_if.sum,       32'd388);
        chk("b_ovf_1",      b_if.sum_ovf,   32'd1);
        tick();
        chk("a_valid_1cyc", a_if.sum_valid, 32'd0);
        chk("b_valid_1cyc", b_if.sum_valid, 32'd0);

        // Overflow flag clears on the next group
        b_if.prod_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b_if.prod = 8'(i);
            tick();
        end
        b_if.prod_valid = 1'b0;
        chk("b_sum_10",   b_if.sum,       32'd10);
        chk("b_ovf_clr",  b_if.sum_ovf,   32'd0);
        chk("b_valid",    b_if.sum_valid, 32'd1);
        tick();

        // Backpressure: result held, upstream stalled, then 7 accepted on release
        a_if.sum_ready = 1'b0;
        feed_a('{8'd10, 8'd20, 8'd30, 8'd40}, 4);
        chk("bp_valid", a_if.sum_valid, 32'd1);
        chk("bp_sum",   a_if.sum,       32'd100);
        a_if.prod_valid = 1'b1;
        a_if.prod = 8'd7;
        #1;
        chk("bp_rdy_lo", a_if.prod_ready, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_sum",   a_if.sum,        32'd100);
            chk("bp_hold_valid", a_if.sum_valid,  32'd1);
            chk("bp_hold_rdy",   a_if.prod_ready, 32'd0);
            chk("bp_hold_cnt",   a_if.grp_cnt,    32'd0);
        end
        a_if.sum_ready = 1'b1;
        #1;
        chk("bp_rdy_hi", a_if.prod_ready, 32'd1);
        tick();
        a_if.prod_valid = 1'b0;
        chk("bp_cnt_1",   a_if.grp_cnt,   32'd1);
        chk("bp_drained", a_if.sum_valid, 32'd0);
        feed_a('{8'd1, 8'd1, 8'd1, 8'd0}, 3);
        chk("bp_next_sum", a_if.sum, 32'd10);
        tick();

        // clr mid-group: 30 dropped, counter cleared, last sum kept
        feed_a('{8'd10, 8'd20, 8'd0, 8'd0}, 2);
        chk("clr_pre_cnt", a_if.grp_cnt, 32'd2);
        a_if.prod_valid = 1'b1;
        a_if.prod = 8'd30;
        clr = 1'b1;
        #1;
        chk("clr_rdy", a_if.prod_ready, 32'd0);
        tick();
        clr = 1'b0;
        a_if.prod_valid = 1'b0;
        chk("clr_cnt",   a_if.grp_cnt,   32'd0);
        chk("clr_valid", a_if.sum_valid, 32'd0);
        chk("clr_sum",   a_if.sum,       32'd10);
        feed_a('{8'd1, 8'd1, 8'd1, 8'd1}, 4);
        chk("clr_sum_4", a_if.sum,     32'd4);
        chk("clr_ovf",   a_if.sum_ovf, 32'd0);
        tick();

        // LEN=1 streams one result per cycle
        c_if.prod_valid = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            c_if.prod = 8'(i);
            tick();
            chk("len1_valid", c_if.sum_valid, 32'd1);
            chk("len1_sum",   c_if.sum,       32'(i));
        end
        c_if.prod_valid = 1'b0;
        tick();
        chk("len1_drain", c_if.sum_valid, 32'd0);

        // Reset asserted mid-group discards the partial sum
        feed_a('{8'd3, 8'd4, 8'd0, 8'd0}, 2);
        chk("rst2_pre_cnt", a_if.grp_cnt, 32'd2);
        rst_n = 1'b0;
        tick();
        chk("rst2_cnt",   a_if.grp_cnt,    32'd0);
        chk("rst2_sum",   a_if.sum,        32'd0);
        chk("rst2_valid", a_if.sum_valid,  32'd0);
        chk("rst2_ovf",   a_if.sum_ovf,    32'd0);
        chk("rst2_rdy",   a_if.prod_ready, 32'd1);
        rst_n = 1'b1;
        tick();
        feed_a('{8'd2, 8'd2, 8'd2, 8'd2}, 4);
        chk("rst2_sum_8", a_if.sum, 32'd8);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
